stream_demux1_2: RTL and testbench
==================================

// Module: stream_demux1_2
// PURPOSE
//   1-to-2 registered stream demultiplexer: the steering counterpart of mux2_1.
//   Routes each word on a single valid/ready input stream to output 0 or 1, chosen per word by in_sel.
//   Each output has a 1-entry holding register, so the block also acts as a pipeline slice.
//   Used to split a pipeline result stream between two consumers, for example writeback and a side unit.
// PARAMETERS
//   WIDTH    8  data width of input and both outputs
//   COUNT_W  8  width of per-output delivered-word counters
// PORTS
//   clk         in   1        clock; all state updates on the rising edge
//   rst         in   1        synchronous, active-high reset
//   in_valid    in   1        input word valid
//   in_ready    out  1        block can accept the input word this cycle
//   in_data     in   WIDTH    input word
//   in_sel      in   1        destination: 0 -> out0, 1 -> out1
//   out0_valid  out  1        out0 holds a word
//   out0_ready  in   1        consumer 0 accepts
//   out0_data   out  WIDTH    out0 word
//   out1_valid  out  1        out1 holds a word
//   out1_ready  in   1        consumer 1 accepts
//   out1_data   out  WIDTH    out1 word
//   cnt0        out  COUNT_W  words delivered on out0 (modulo 2^COUNT_W)
//   cnt1        out  COUNT_W  words delivered on out1 (modulo 2^COUNT_W)
// BEHAVIOUR
//   - Reset (rst=1 at edge): outN_valid=0, outN_data=0, cntN=0. Buffered words are dropped,
//     including when reset arrives mid-transfer. in_ready is combinational and follows the reset slot state.
//   - in_ready = in_sel ? (!out1_valid | out1_ready) : (!out0_valid | out0_ready).
//     This is a combinational path from outN_ready to in_ready.
//   - Input handshake: in_valid & in_ready. Upstream holds in_data and in_sel stable while in_valid=1 and not accepted.
//   - Latency is 1 cycle. A word accepted at edge k appears on out[in_sel] after edge k. Throughput is 1 word per cycle per output.
//   - Slot N update at each edge, with ld = accept & (in_sel==N) and tk = outN_valid & outN_ready:
//     - ld: outN_data <= in_data, outN_valid <= 1. This covers a simultaneous tk, where the slot drains and refills in the same cycle.
//     - tk & !ld: outN_valid <= 0, and outN_data keeps its last value.
//     - otherwise: hold.
//   - outN_valid and outN_data are stable while outN_valid & !outN_ready (no retraction).
//   - The non-selected output drains independently in the same cycle. Its ready never gates the input.
//   - Backpressure: a full slot with outN_ready=0 forces in_ready=0 only for words targeting N.
//     Head-of-line blocking is accepted, with no reordering.
//   - cntN increments by 1 on each tk and wraps from 2^COUNT_W-1 to 0.
//   - No word is duplicated or lost. The total of cnt0+cnt1 equals accepted words minus words still held in slots.
//   - No X on any output after the first reset edge.
// TESTING
//   1. Reset: rst=1 for 2 cycles with in_valid=1 -> out0_valid=out1_valid=0, cnt0=cnt1=0, no words delivered.
//   2. Steering: send 8'h11 sel=0, then 8'h32 sel=1, both readies=1 -> out0_data=8'h11 and out1_data=8'h32,
//      each valid exactly 1 cycle after acceptance; cnt0=1, cnt1=1.
//   3. Backpressure: out0_ready=0, send 8'hAF sel=0, then 8'hFA sel=0 -> 8'hAF is held stable and in_ready=0.
//      After out0_ready=1, 8'hAF is delivered, then 8'hFA; order is preserved.
//   4. Independent drain: out0 stalled and full; send 8'h55 sel=1 with out1_ready=1 -> accepted, out1_data=8'h55, out0 unchanged.
//   5. Streaming: 20 back-to-back words alternating sel with both readies=1 -> in_ready stays 1 throughout;
//      cnt0=10, cnt1=10; data order is checked against a scoreboard.
//   6. Wrap and mid-op reset: with COUNT_W=2, deliver 5 words on out1 -> cnt1=1.
//      Then assert rst while out1 holds an undelivered word -> out1_valid=0 next cycle and that word is never delivered.

Source files
------------

// File: rtl/stream_demux1_2_if.sv
// Valid/ready bundle for the 1-to-2 stream demultiplexer.
// The slave side is the demux; the master side drives it.
interface stream_demux1_2_if #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic               in_sel;
    logic               out0_valid;
    logic               out0_ready;
    logic [WIDTH-1:0]   out0_data;
    logic               out1_valid;
    logic               out1_ready;
    logic [WIDTH-1:0]   out1_data;
    logic [COUNT_W-1:0] cnt0;
    logic [COUNT_W-1:0] cnt1;

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_sel,
        input  out0_ready,
        input  out1_ready,
        output in_ready,
        output out0_valid,
        output out0_data,
        output out1_valid,
        output out1_data,
        output cnt0,
        output cnt1
    );

    modport master (
        output in_valid,
        output in_data,
        output in_sel,
        output out0_ready,
        output out1_ready,
        input  in_ready,
        input  out0_valid,
        input  out0_data,
        input  out1_valid,
        input  out1_data,
        input  cnt0,
        input  cnt1
    );
endinterface

// File: rtl/stream_demux1_2.sv
// 1-to-2 registered stream demultiplexer with a one-word slot
// per output and per-output delivered-word counters.
module stream_demux1_2 #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    stream_demux1_2_if.slave bus
);
    logic               v0;
    logic               v1;
    logic [WIDTH-1:0]   d0;
    logic [WIDTH-1:0]   d1;
    logic [COUNT_W-1:0] c0;
    logic [COUNT_W-1:0] c1;
    logic               rdy;
    logic               acc;
    logic               ld0;
    logic               ld1;
    logic               tk0;
    logic               tk1;

    // Only the addressed slot can stall the input.
    always_comb begin
        rdy = 1'b0;
        unique case (bus.in_sel)
            1'b0: rdy = !v0 || bus.out0_ready;
            1'b1: rdy = !v1 || bus.out1_ready;
            default: rdy = 1'b0;
        endcase
    end

    always_comb begin
        acc = bus.in_valid && rdy;
        ld0 = acc && !bus.in_sel;
        ld1 = acc && bus.in_sel;
        tk0 = v0 && bus.out0_ready;
        tk1 = v1 && bus.out1_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v0 <= 1'b0;
            d0 <= '0;
            c0 <= '0;
        end else begin
            if (ld0) begin
                v0 <= 1'b1;
                d0 <= bus.in_data;
            end else if (tk0) begin
                v0 <= 1'b0;
            end
            if (tk0) c0 <= c0 + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            d1 <= '0;
            c1 <= '0;
        end else begin
            if (ld1) begin
                v1 <= 1'b1;
                d1 <= bus.in_data;
            end else if (tk1) begin
                v1 <= 1'b0;
            end
            if (tk1) c1 <= c1 + 1'b1;
        end
    end

    assign bus.in_ready   = rdy;
    assign bus.out0_valid = v0;
    assign bus.out0_data  = d0;
    assign bus.out1_valid = v1;
    assign bus.out1_data  = d1;
    assign bus.cnt0       = c0;
    assign bus.cnt1       = c1;
endmodule

// File: tb/tb_stream_demux1_2.sv
// Bench for stream_demux1_2: directed steps plus random traffic
// against a queue-based reference; a 2-bit-counter copy checks wrap.
module tb_stream_demux1_2;
    logic clk;
    logic rst;

    stream_demux1_2_if #(.WIDTH(8), .COUNT_W(8)) bus ();
    stream_demux1_2_if #(.WIDTH(8), .COUNT_W(2)) bus2 ();

    stream_demux1_2 #(.WIDTH(8), .COUNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    stream_demux1_2 #(.WIDTH(8), .COUNT_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    assign bus2.in_valid   = bus.in_valid;
    assign bus2.in_data    = bus.in_data;
    assign bus2.in_sel     = bus.in_sel;
    assign bus2.out0_ready = bus.out0_ready;
    assign bus2.out1_ready = bus.out1_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int checks  = 0;

    // Reference: each slot is a queue of at most one word.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] last0;
    logic [7:0] last1;
    int         n0;
    int         n1;
    logic       accepted;
    logic       rdy_seen_low;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic ir;
        logic acc;
        logic tk0;
        logic tk1;
        @(negedge clk);
        ir = bus.in_sel ? (q1.size() == 0 || bus.out1_ready)
                        : (q0.size() == 0 || bus.out0_ready);
        if (!rst) chk("in_ready", 32'(bus.in_ready), 32'(ir));
        if (!ir) rdy_seen_low = 1'b1;
        acc = bus.in_valid && ir;
        tk0 = q0.size() != 0 && bus.out0_ready;
        tk1 = q1.size() != 0 && bus.out1_ready;
        if (tk0) chk("deliver0", 32'(bus.out0_data), 32'(q0[0]));
        if (tk1) chk("deliver1", 32'(bus.out1_data), 32'(q1[0]));
        @(posedge clk);
        vectors++;
        if (rst) begin
            q0.delete();
            q1.delete();
            last0 = 8'h00;
            last1 = 8'h00;
            n0 = 0;
            n1 = 0;
            accepted = 1'b0;
        end else begin
            if (tk0) begin
                void'(q0.pop_front());
                n0++;
            end
            if (tk1) begin
                void'(q1.pop_front());
                n1++;
            end
            if (acc && bus.in_sel) begin
                q1.push_back(bus.in_data);
                last1 = bus.in_data;
            end else if (acc) begin
                q0.push_back(bus.in_data);
                last0 = bus.in_data;
            end
            accepted = acc;
        end
        #1;
        chk("out0_valid", 32'(bus.out0_valid), 32'(q0.size() != 0));
        chk("out1_valid", 32'(bus.out1_valid), 32'(q1.size() != 0));
        chk("out0_data", 32'(bus.out0_data), 32'(last0));
        chk("out1_data", 32'(bus.out1_data), 32'(last1));
        chk("cnt0", 32'(bus.cnt0), 32'(n0 % 256));
        chk("cnt1", 32'(bus.cnt1), 32'(n1 % 256));
        chk("cnt0_w2", 32'(bus2.cnt0), 32'(n0 % 4));
        chk("cnt1_w2", 32'(bus2.cnt1), 32'(n1 % 4));
        chk("out1_valid_w2", 32'(bus2.out1_valid), 32'(q1.size() != 0));
    endtask

    task automatic drive(logic v, logic [7:0] d, logic s);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_sel   = s;
    endtask

    initial begin
        last0 = 8'h00;
        last1 = 8'h00;
        n0 = 0;
        n1 = 0;
        accepted = 1'b0;
        rdy_seen_low = 1'b0;
        rst = 1'b1;
        bus.out0_ready = 1'b1;
        bus.out1_ready = 1'b1;
        drive(1'b1, 8'h77, 1'b0);

        // Reset held two cycles with a word offered
        cycle();
        cycle();
        chk("rst_v0", 32'(bus.out0_valid), 32'd0);
        chk("rst_cnt1", 32'(bus.cnt1), 32'd0);
        rst = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        cycle();

        // Steering
        drive(1'b1, 8'h11, 1'b0);
        cycle();
        chk("steer_d0", 32'(bus.out0_data), 32'h11);
        drive(1'b1, 8'h32, 1'b1);
        cycle();
        chk("steer_d1", 32'(bus.out1_data), 32'h32);
        drive(1'b0, 8'h00, 1'b0);
        cycle();
        chk("steer_cnt0", 32'(bus.cnt0), 32'd1);
        chk("steer_cnt1", 32'(bus.cnt1), 32'd1);

        // Backpressure on out0
        bus.out0_ready = 1'b0;
        drive(1'b1, 8'hAF, 1'b0);
        cycle();
        drive(1'b1, 8'hFA, 1'b0);
        rdy_seen_low = 1'b0;
        cycle();
        cycle();
        chk("bp_hold", 32'(bus.out0_data), 32'hAF);
        chk("bp_stall", 32'(rdy_seen_low), 32'd1);
        bus.out0_ready = 1'b1;
        cycle();
        chk("bp_next", 32'(bus.out0_data), 32'hFA);
        drive(1'b0, 8'h00, 1'b0);
        cycle();

        // Independent drain while out0 is stalled and full
        bus.out0_ready = 1'b0;
        drive(1'b1, 8'h3C, 1'b0);
        cycle();
        drive(1'b1, 8'h55, 1'b1);
        cycle();
        chk("ind_d1", 32'(bus.out1_data), 32'h55);
        chk("ind_d0", 32'(bus.out0_data), 32'h3C);
        drive(1'b0, 8'h00, 1'b0);
        cycle();
        bus.out0_ready = 1'b1;
        cycle();

        // Streaming from a clean reset
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        rdy_seen_low = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 8'(8'hA0 + i), 1'(i % 2));
            cycle();
        end
        drive(1'b0, 8'h00, 1'b0);
        cycle();
        chk("str_ready", 32'(rdy_seen_low), 32'd0);
        chk("str_cnt0", 32'(bus.cnt0), 32'd10);
        chk("str_cnt1", 32'(bus.cnt1), 32'd10);

        // Counter wrap on the 2-bit copy, then reset mid-transfer
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(8'h60 + i), 1'b1);
            cycle();
        end
        drive(1'b0, 8'h00, 1'b0);
        cycle();
        chk("wrap_cnt1", 32'(bus2.cnt1), 32'd1);
        bus.out1_ready = 1'b0;
        drive(1'b1, 8'hEE, 1'b1);
        cycle();
        drive(1'b0, 8'h00, 1'b0);
        rst = 1'b1;
        cycle();
        chk("mid_rst_v1", 32'(bus2.out1_valid), 32'd0);
        rst = 1'b0;
        bus.out1_ready = 1'b1;
        cycle();
        cycle();
        chk("mid_rst_cnt1", 32'(bus2.cnt1), 32'd0);

        // Random traffic; upstream holds an unaccepted word
        for (int i = 0; i < 400; i++) begin
            if (!(bus.in_valid && !accepted)) begin
                drive(1'($urandom_range(0, 3) != 0),
                      8'($urandom), 1'($urandom));
            end
            bus.out0_ready = 1'($urandom_range(0, 2) != 0);
            bus.out1_ready = 1'($urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 60) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end
endmodule
